usb_tx_sequencer: RTL and testbench

Byte-level packet sequencer for the USB transmit path. On a `tx_packet` request it emits, in order, SYNC, PID, up to 64 payload bytes popped from the TX data FIFO, and the CRC16 (DATA0 only), as a valid/ready byte stream toward the serializer. It then requests EOP signalling. It sits between the endpoint/AHB-side TX buffer and the bit-level shift/stuff/encode chain, and computes CRC16 on the fly.

---
 rtl/usb_tx_sequencer.sv | 165 ++++++++++++++++
 tb/tb_usb_tx_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_sequencer.sv
// rtl/usb_tx_sequencer.sv - USB TX byte sequencer: SYNC, PID, payload, CRC16, then EOP request
// Payload bytes are popped from a first-word fall-through FIFO and CRC16-USB is computed on the fly.

module usb_crc16_byte (
   input  logic [15:0] crc,
   input  logic [7:0]  data,
   output logic [15:0] crc_next
);
   // Reflected 0x8005 (0xA001), LSB first, all eight bits in one cycle.
   always_comb begin
      crc_next = crc ^ {8'h00, data};
      for (int i = 0; i < 8; i++) begin
         crc_next = crc_next[0] ? ((crc_next >> 1) ^ 16'hA001) : (crc_next >> 1);
      end
   end
endmodule

module usb_tx_sequencer #(
   parameter int MAX_PAYLOAD = 64
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [1:0] tx_packet,
   input  logic [6:0] tx_packet_data_size,
   input  logic [7:0] tx_packet_data,
   output logic       get_tx_packet_data,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   input  logic       byte_ready,
   output logic       eop_req,
   input  logic       eop_done,
   output logic       tx_busy,
   output logic       tx_done
);
   typedef enum logic [2:0] {
      S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_EOP, S_DONE
   } state_t;

   localparam logic [1:0] PKT_DATA0 = 2'd1;
   localparam logic [6:0] MAX_SIZE  = 7'(MAX_PAYLOAD);

   state_t      state;
   logic [1:0]  pkt;
   logic [6:0]  size;
   logic [6:0]  count;
   logic [15:0] crc;
   logic [15:0] crc_next;
   logic [7:0]  byte_reg;
   logic        xfer;

   function automatic logic [7:0] pid_byte(input logic [1:0] p);
      case (p)
         2'd1:    pid_byte = 8'hC3;
         2'd2:    pid_byte = 8'hD2;
         2'd3:    pid_byte = 8'h5A;
         default: pid_byte = 8'h00;
      endcase
   endfunction

   usb_crc16_byte u_crc (
      .crc      (crc),
      .data     (tx_packet_data),
      .crc_next (crc_next)
   );

   assign xfer               = byte_valid & byte_ready;
   assign get_tx_packet_data = (state == S_DATA) & byte_ready;
   // The FIFO head is passed straight through; it only moves on a pop, so it holds during stalls.
   assign byte_out           = (state == S_DATA) ? tx_packet_data : byte_reg;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= S_IDLE;
         pkt        <= 2'd0;
         size       <= 7'd0;
         count      <= 7'd0;
         crc        <= 16'hFFFF;
         byte_reg   <= 8'h00;
         byte_valid <= 1'b0;
         eop_req    <= 1'b0;
         tx_busy    <= 1'b0;
         tx_done    <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (tx_packet != 2'd0) begin
                  pkt        <= tx_packet;
                  size       <= (tx_packet_data_size > MAX_SIZE) ? MAX_SIZE : tx_packet_data_size;
                  count      <= 7'd0;
                  crc        <= 16'hFFFF;
                  byte_reg   <= 8'h80;
                  byte_valid <= 1'b1;
                  tx_busy    <= 1'b1;
                  state      <= S_SYNC;
               end
            end
            S_SYNC: begin
               if (xfer) begin
                  byte_reg <= pid_byte(pkt);
                  state    <= S_PID;
               end
            end
            S_PID: begin
               if (xfer) begin
                  if (pkt != PKT_DATA0) begin
                     byte_reg   <= 8'h00;
                     byte_valid <= 1'b0;
                     eop_req    <= 1'b1;
                     state      <= S_EOP;
                  end else if (size == 7'd0) begin
                     byte_reg <= ~crc[7:0];
                     state    <= S_CRC_LO;
                  end else begin
                     byte_reg <= 8'h00;
                     state    <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (xfer) begin
                  count <= count + 7'd1;
                  crc   <= crc_next;
                  if (count + 7'd1 == size) begin
                     byte_reg <= ~crc_next[7:0];
                     state    <= S_CRC_LO;
                  end
               end
            end
            S_CRC_LO: begin
               if (xfer) begin
                  byte_reg <= ~crc[15:8];
                  state    <= S_CRC_HI;
               end
            end
            S_CRC_HI: begin
               if (xfer) begin
                  byte_reg   <= 8'h00;
                  byte_valid <= 1'b0;
                  eop_req    <= 1'b1;
                  state      <= S_EOP;
               end
            end
            S_EOP: begin
               if (eop_done) begin
                  eop_req <= 1'b0;
                  tx_done <= 1'b1;
                  state   <= S_DONE;
               end
            end
            S_DONE: begin
               tx_busy <= 1'b0;
               state   <= S_IDLE;
            end
            default: begin
               byte_reg   <= 8'h00;
               byte_valid <= 1'b0;
               eop_req    <= 1'b0;
               tx_busy    <= 1'b0;
               state      <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_usb_tx_sequencer.sv
// tb/tb_usb_tx_sequencer.sv - directed table-driven bench for usb_tx_sequencer
// A FIFO model feeds payload; byte streams are compared against an independent CRC16-USB model.

module tb_usb_tx_sequencer;
   logic       clk = 1'b0;
   logic       n_rst;
   logic [1:0] tx_packet;
   logic [6:0] tx_packet_data_size;
   logic [7:0] tx_packet_data;
   logic       get_tx_packet_data;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic       byte_ready;
   logic       eop_req;
   logic       eop_done;
   logic       tx_busy;
   logic       tx_done;

   int checks = 0;
   int errors = 0;

   logic [7:0] fifo_mem [0:255];
   int rd_ptr    = 0;
   int pop_count = 0;

   typedef struct {
      logic [1:0] code;
      logic [6:0] size;
      bit         rand_ready;
      int         nak_at;
      int         abort_at;
      logic [7:0] exp_pid;
   } vec_t;

   vec_t vecs [8];

   always #5 clk = ~clk;

   usb_tx_sequencer #(.MAX_PAYLOAD(64)) dut (
      .clk                 (clk),
      .n_rst               (n_rst),
      .tx_packet           (tx_packet),
      .tx_packet_data_size (tx_packet_data_size),
      .tx_packet_data      (tx_packet_data),
      .get_tx_packet_data  (get_tx_packet_data),
      .byte_out            (byte_out),
      .byte_valid          (byte_valid),
      .byte_ready          (byte_ready),
      .eop_req             (eop_req),
      .eop_done            (eop_done),
      .tx_busy             (tx_busy),
      .tx_done             (tx_done)
   );

   assign tx_packet_data = fifo_mem[rd_ptr[7:0]];

   always @(posedge clk) begin
      if (get_tx_packet_data) begin
         rd_ptr    <= rd_ptr + 1;
         pop_count <= pop_count + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Non-reflected 0x8005 over bit-reversed input, reflected and inverted at the end.
   function automatic logic [15:0] crc_model(input int base, input int n);
      logic [15:0] r;
      logic [15:0] o;
      logic [7:0]  d;
      logic        fb;
      r = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         d = fifo_mem[(base + i) % 256];
         for (int b = 0; b < 8; b++) begin
            fb = r[15] ^ d[b];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h8005;
         end
      end
      for (int b = 0; b < 16; b++) o[b] = r[15 - b];
      return ~o;
   endfunction

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_valid"}, {31'd0, byte_valid}, 32'd0);
      chk({tag, "_byte"}, {24'd0, byte_out}, 32'd0);
      chk({tag, "_pop"}, {31'd0, get_tx_packet_data}, 32'd0);
      chk({tag, "_eop_req"}, {31'd0, eop_req}, 32'd0);
      chk({tag, "_busy"}, {31'd0, tx_busy}, 32'd0);
      chk({tag, "_done"}, {31'd0, tx_done}, 32'd0);
   endtask

   task automatic run_packet(input vec_t v);
      logic [7:0]  exp_q[$];
      logic [7:0]  got_q[$];
      logic [15:0] crc_out;
      logic [7:0]  prev_byte;
      bit          prev_stall;
      bit          aborted;
      bit          finished;
      int          base;
      int          pops0;
      int          n;
      base       = rd_ptr;
      pops0      = pop_count;
      prev_stall = 1'b0;
      prev_byte  = 8'h00;
      aborted    = 1'b0;
      finished   = 1'b0;
      n = (v.code == 2'd1) ? ((v.size > 7'd64) ? 64 : int'(v.size)) : 0;

      exp_q.push_back(8'h80);
      exp_q.push_back(v.exp_pid);
      if (v.code == 2'd1) begin
         for (int i = 0; i < n; i++) exp_q.push_back(fifo_mem[(base + i) % 256]);
         crc_out = crc_model(base, n);
         exp_q.push_back(crc_out[7:0]);
         exp_q.push_back(crc_out[15:8]);
      end

      @(negedge clk);
      tx_packet           = v.code;
      tx_packet_data_size = v.size;
      byte_ready          = 1'b1;
      @(negedge clk);
      tx_packet           = 2'd0;
      tx_packet_data_size = 7'd5;
      chk("latency_valid", {31'd0, byte_valid}, 32'd1);
      chk("latency_sync", {24'd0, byte_out}, 32'h80);

      for (int cyc = 0; cyc < 1000; cyc++) begin
         tx_packet  = (v.nak_at >= 0 && got_q.size() == v.nak_at) ? 2'd3 : 2'd0;
         byte_ready = v.rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         eop_done   = eop_req;
         #1;
         if (prev_stall) chk("stall_hold", {24'd0, byte_out}, {24'd0, prev_byte});
         if (tx_done) begin
            finished = 1'b1;
            break;
         end
         if (v.abort_at >= 0 && got_q.size() == v.abort_at) begin
            n_rst = 1'b0;
            #1;
            check_reset_outputs("abort");
            @(negedge clk);
            n_rst   = 1'b1;
            aborted = 1'b1;
            break;
         end
         if (byte_valid && byte_ready) got_q.push_back(byte_out);
         prev_stall = byte_valid && !byte_ready;
         prev_byte  = byte_out;
         @(negedge clk);
      end
      tx_packet  = 2'd0;
      eop_done   = 1'b0;
      byte_ready = 1'b1;

      if (aborted) begin
         chk("abort_pops", pop_count - pops0, v.abort_at - 2);
      end else begin
         chk("tx_done_seen", {31'd0, finished}, 32'd1);
         chk("byte_count", got_q.size(), exp_q.size());
         if (got_q.size() == exp_q.size())
            for (int i = 0; i < exp_q.size(); i++)
               chk($sformatf("byte%0d", i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
         chk("pops", pop_count - pops0, n);
         @(negedge clk);
         #1;
         chk("done_single", {31'd0, tx_done}, 32'd0);
         chk("idle_busy", {31'd0, tx_busy}, 32'd0);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) fifo_mem[i] = 8'(i);
      n_rst               = 1'b0;
      tx_packet           = 2'd0;
      tx_packet_data_size = 7'd0;
      byte_ready          = 1'b0;
      eop_done            = 1'b0;

      vecs[0] = '{2'd2, 7'd0,   1'b0, -1, -1, 8'hD2};
      vecs[1] = '{2'd1, 7'd0,   1'b0, -1, -1, 8'hC3};
      vecs[2] = '{2'd1, 7'd4,   1'b0, -1, -1, 8'hC3};
      vecs[3] = '{2'd1, 7'd3,   1'b1, -1, -1, 8'hC3};
      vecs[4] = '{2'd1, 7'd100, 1'b0, 20, -1, 8'hC3};
      vecs[5] = '{2'd1, 7'd30,  1'b0, -1, 12, 8'hC3};
      vecs[6] = '{2'd3, 7'd0,   1'b0, -1, -1, 8'h5A};
      vecs[7] = '{2'd1, 7'd64,  1'b1, -1, -1, 8'hC3};

      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      n_rst = 1'b1;
      @(negedge clk);

      // Idle requests of zero must not start anything.
      byte_ready = 1'b1;
      @(negedge clk);
      chk("idle_none_busy", {31'd0, tx_busy}, 32'd0);

      for (int k = 0; k < 8; k++) run_packet(vecs[k]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
